// File: rtl/soundrive_fifo.sv
// Soundrive/Covox-style multi-channel 8-bit DAC on the Z80 I/O bus. Each channel can
// optionally be backed by a sample FIFO that is drained by an external sample-rate tick.
module soundrive_fifo #(
  parameter int          CHANNELS    = 4,
  parameter int          DEPTH       = 16,
  parameter bit          BUFFERED    = 1'b1,
  parameter logic [31:0] PORTS       = {8'h5F, 8'h4F, 8'h1F, 8'h0F},
  parameter logic [7:0]  STATUS_PORT = 8'hDF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  iorq,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [7:0]            a,
  input  logic [7:0]            d,
  input  logic                  tick,
  output logic [8*CHANNELS-1:0] q,
  output logic [7:0]            dout,
  output logic                  doe
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [CHANNELS-1:0] wsel;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] underrun;
  logic [CHANNELS-1:0] wprev_q;
  logic                rsel;
  logic                rprev_q;
  logic                clrUnder;

  always_comb begin
    wsel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wsel[i] = !iorq && !wr && (a == PORTS[8*i +: 8]);
    end
  end

  // Edge detect on ce cycles: one push per I/O cycle however long the strobe is held.
  assign push     = {CHANNELS{ce}} & wsel & ~wprev_q;
  assign rsel     = !iorq && !rd && (a == STATUS_PORT);
  assign doe      = rsel;
  assign clrUnder = ce && rprev_q && !rsel;

  always_ff @(posedge clock) begin
    if (reset) begin
      wprev_q <= '0;
      rprev_q <= 1'b0;
    end else if (ce) begin
      wprev_q <= wsel;
      rprev_q <= rsel;
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      dout[i]     = underrun[i];
      dout[4 + i] = full[i];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : gChan
    logic [7:0] sample_q;

    assign q[8*g +: 8] = sample_q;

    if (BUFFERED) begin : gFifo
      logic [7:0]    mem_q [DEPTH];
      logic [AW-1:0] wrPtr_q;
      logic [AW-1:0] rdPtr_q;
      logic [CW-1:0] count_q;
      logic [CW-1:0] count_d;
      logic          underrun_q;
      logic          pop;
      logic          accept;

      assign full[g]     = (count_q == CW'(DEPTH));
      assign pop         = tick && (count_q != '0);
      // A same-clock pop frees the slot that a push into a full FIFO lands in.
      assign accept      = push[g] && (!full[g] || tick);
      assign count_d     = count_q + CW'(accept) - CW'(pop);
      assign underrun[g] = underrun_q;

      always_ff @(posedge clock) begin
        if (accept) begin
          mem_q[wrPtr_q] <= d;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          wrPtr_q    <= '0;
          rdPtr_q    <= '0;
          count_q    <= '0;
          sample_q   <= '0;
          underrun_q <= 1'b0;
        end else begin
          if (accept) begin
            wrPtr_q <= wrPtr_q + AW'(1);
          end
          if (pop) begin
            sample_q <= mem_q[rdPtr_q];
            rdPtr_q  <= rdPtr_q + AW'(1);
          end
          count_q <= count_d;
          if (tick && (count_q == '0)) begin
            underrun_q <= 1'b1;
          end else if (clrUnder) begin
            underrun_q <= 1'b0;
          end
        end
      end
    end else begin : gDirect
      logic unused_inputs;

      assign unused_inputs = tick | clrUnder;
      assign full[g]       = 1'b0;
      assign underrun[g]   = 1'b0;

      always_ff @(posedge clock) begin
        if (reset) begin
          sample_q <= '0;
        end else if (push[g]) begin
          sample_q <= d;
        end
      end
    end
  end

endmodule

// File: tb/tb_soundrive_fifo.sv
// Bench for soundrive_fifo: a FIFO-mode and a direct-mode instance share one bus and are
// compared against a queue-based model of the channel behaviour.
module tb_soundrive_fifo;

  localparam int         DEPTH = 16;
  localparam logic [7:0] P0    = 8'h0F;
  localparam logic [7:0] P1    = 8'h1F;
  localparam logic [7:0] P2    = 8'h4F;
  localparam logic [7:0] P3    = 8'h5F;
  localparam logic [7:0] PS    = 8'hDF;

  logic        clock = 1'b0;
  logic        reset, ce, iorq, wr, rd, tick;
  logic [7:0]  a, d;
  logic [31:0] qF, qD;
  logic [7:0]  doutF, doutD;
  logic        doeF, doeD;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [7:0] fifoM [4][$];
  logic [7:0] qM  [4];
  logic [7:0] dqM [4];
  logic [3:0] urM;

  always #5 clock = ~clock;

  soundrive_fifo #(.CHANNELS(4), .DEPTH(DEPTH), .BUFFERED(1'b1)) dutF (
    .clock(clock), .reset(reset), .ce(ce), .iorq(iorq), .wr(wr), .rd(rd),
    .a(a), .d(d), .tick(tick), .q(qF), .dout(doutF), .doe(doeF)
  );

  soundrive_fifo #(.CHANNELS(4), .DEPTH(DEPTH), .BUFFERED(1'b0)) dutD (
    .clock(clock), .reset(reset), .ce(ce), .iorq(iorq), .wr(wr), .rd(rd),
    .a(a), .d(d), .tick(tick), .q(qD), .dout(doutD), .doe(doeD)
  );

  function automatic int chOf(input logic [7:0] port);
    case (port)
      P0:      return 0;
      P1:      return 1;
      P2:      return 2;
      P3:      return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] qExp();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = qM[i];
    return r;
  endfunction

  function automatic logic [31:0] dqExp();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = dqM[i];
    return r;
  endfunction

  function automatic logic [7:0] statusExp();
    logic [7:0] s;
    s[3:0] = urM;
    for (int i = 0; i < 4; i++) s[4 + i] = (fifoM[i].size() == DEPTH);
    return s;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      fifoM[i].delete();
      qM[i]  = 8'h00;
      dqM[i] = 8'h00;
    end
    urM = 4'h0;
  endtask

  task automatic modelTick();
    for (int i = 0; i < 4; i++) begin
      if (fifoM[i].size() != 0) qM[i] = fifoM[i].pop_front();
      else urM[i] = 1'b1;
    end
  endtask

  task automatic modelPush(input logic [7:0] port, input logic [7:0] data);
    int ch;
    ch = chOf(port);
    if (ch >= 0) begin
      if (fifoM[ch].size() < DEPTH) fifoM[ch].push_back(data);
      dqM[ch] = data;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic busIdle();
    iorq = 1'b1; wr = 1'b1; rd = 1'b1; a = 8'h00; d = 8'h00; tick = 1'b0; ce = 1'b1;
  endtask

  task automatic doReset();
    busIdle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    modelReset();
  endtask

  // One OUT cycle whose strobe spans holdCe enabled cycles, with random ce gaps in between.
  task automatic ioWrite(input logic [7:0] port, input logic [7:0] data, input int holdCe);
    int seen;
    int tries;
    seen = 0;
    tries = 0;
    iorq = 1'b0; wr = 1'b0; a = port; d = data; tick = 1'b0;
    while (seen < holdCe) begin
      ce = (tries > 8) ? 1'b1 : ($urandom_range(0, 2) != 0);
      tries++;
      step();
      if (ce) begin
        if (seen == 0) modelPush(port, data);
        seen++;
      end
    end
    busIdle();
    step();
  endtask

  task automatic pushTick(input logic [7:0] port, input logic [7:0] data);
    iorq = 1'b0; wr = 1'b0; a = port; d = data; ce = 1'b1; tick = 1'b1;
    step();
    modelTick();
    modelPush(port, data);
    tick = 1'b0;
    step();
    busIdle();
    step();
  endtask

  task automatic doTick();
    busIdle();
    ce = 1'($urandom_range(0, 1));
    tick = 1'b1;
    step();
    modelTick();
    busIdle();
  endtask

  task automatic doRead();
    busIdle();
    iorq = 1'b0; rd = 1'b0; a = PS;
    step();
    busIdle();
    step();
    urM = 4'h0;
  endtask

  task automatic test_reset();
    busIdle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    modelReset();
    nCompared++;
    if (qF !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_qF: got %h want %h", qF, 32'h0); end
    nCompared++;
    if (qD !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_qD: got %h want %h", qD, 32'h0); end
    nCompared++;
    if (doutF !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_dout: got %h want %h", doutF, 8'h00); end
    nCompared++;
    if (doeF !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_doe: got %b want %b", doeF, 1'b0); end
  endtask

  task automatic test_single_push();
    ioWrite(P0, 8'h80, 5);
    nCompared++;
    if (qF !== 32'h0) begin nMismatched++; $display("[TB] FAIL single_no_tick: got %h want %h", qF, 32'h0); end
    doTick();
    nCompared++;
    if (qF[7:0] !== 8'h80) begin nMismatched++; $display("[TB] FAIL single_first_tick: got %h want %h", qF[7:0], 8'h80); end
    nCompared++;
    if (qF !== qExp()) begin nMismatched++; $display("[TB] FAIL single_q_all: got %h want %h", qF, qExp()); end
    doTick();
    nCompared++;
    if (qF[7:0] !== 8'h80) begin nMismatched++; $display("[TB] FAIL single_hold: got %h want %h", qF[7:0], 8'h80); end
    nCompared++;
    if (doutF[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_underrun: got %b want %b", doutF[0], 1'b1); end
    nCompared++;
    if (doutF !== statusExp()) begin nMismatched++; $display("[TB] FAIL single_status: got %h want %h", doutF, statusExp()); end
  endtask

  task automatic test_full_drop();
    doRead();
    for (int i = 0; i < 16; i++) ioWrite(P1, 8'(i), 1 + int'($urandom_range(0, 2)));
    nCompared++;
    if (doutF[5] !== 1'b1) begin nMismatched++; $display("[TB] FAIL full_flag: got %b want %b", doutF[5], 1'b1); end
    nCompared++;
    if (doutF !== statusExp()) begin nMismatched++; $display("[TB] FAIL full_status: got %h want %h", doutF, statusExp()); end
    ioWrite(P1, 8'hAA, 2);
    nCompared++;
    if (doutF !== statusExp()) begin nMismatched++; $display("[TB] FAIL full_drop_status: got %h want %h", doutF, statusExp()); end
    for (int i = 0; i < 16; i++) begin
      doTick();
      nCompared++;
      if (qF[15:8] !== 8'(i)) begin nMismatched++; $display("[TB] FAIL full_drain_%0d: got %h want %h", i, qF[15:8], 8'(i)); end
    end
    doTick();
    nCompared++;
    if (qF[15:8] !== 8'h0F) begin nMismatched++; $display("[TB] FAIL full_dropped_byte: got %h want %h", qF[15:8], 8'h0F); end
    nCompared++;
    if (doutF[1] !== 1'b1) begin nMismatched++; $display("[TB] FAIL full_then_underrun: got %b want %b", doutF[1], 1'b1); end
  endtask

  task automatic test_full_push_tick();
    logic [7:0] last;
    for (int i = 0; i < 16; i++) ioWrite(P2, 8'($urandom), 1);
    nCompared++;
    if (doutF[6] !== 1'b1) begin nMismatched++; $display("[TB] FAIL fpt_full: got %b want %b", doutF[6], 1'b1); end
    last = 8'($urandom);
    pushTick(P2, last);
    nCompared++;
    if (doutF[6] !== 1'b1) begin nMismatched++; $display("[TB] FAIL fpt_still_full: got %b want %b", doutF[6], 1'b1); end
    nCompared++;
    if (qF !== qExp()) begin nMismatched++; $display("[TB] FAIL fpt_q: got %h want %h", qF, qExp()); end
    for (int k = 0; k < 40; k++) begin
      last = 8'($urandom);
      pushTick(P2, last);
      nCompared++;
      if (qF[23:16] !== qM[2]) begin nMismatched++; $display("[TB] FAIL fpt_pair_%0d: got %h want %h", k, qF[23:16], qM[2]); end
    end
    for (int i = 0; i < 16; i++) begin
      doTick();
      nCompared++;
      if (qF[23:16] !== qM[2]) begin nMismatched++; $display("[TB] FAIL fpt_drain_%0d: got %h want %h", i, qF[23:16], qM[2]); end
    end
    nCompared++;
    if (qF[23:16] !== last) begin nMismatched++; $display("[TB] FAIL fpt_last_out: got %h want %h", qF[23:16], last); end
    nCompared++;
    if (doutF[6] !== 1'b0) begin nMismatched++; $display("[TB] FAIL fpt_not_full: got %b want %b", doutF[6], 1'b0); end
  endtask

  task automatic test_underrun_push_tick();
    ioWrite(P3, 8'h5A, 1);
    doTick();
    doRead();
    nCompared++;
    if (doutF[3:0] !== 4'h0) begin nMismatched++; $display("[TB] FAIL upt_cleared: got %h want %h", doutF[3:0], 4'h0); end
    pushTick(P3, 8'h33);
    nCompared++;
    if (doutF[3] !== 1'b1) begin nMismatched++; $display("[TB] FAIL upt_underrun: got %b want %b", doutF[3], 1'b1); end
    nCompared++;
    if (qF[31:24] !== 8'h5A) begin nMismatched++; $display("[TB] FAIL upt_q_held: got %h want %h", qF[31:24], 8'h5A); end
    doTick();
    nCompared++;
    if (qF[31:24] !== 8'h33) begin nMismatched++; $display("[TB] FAIL upt_stored: got %h want %h", qF[31:24], 8'h33); end
  endtask

  task automatic test_status_read();
    doTick();
    iorq = 1'b0; rd = 1'b0; a = PS;
    #1;
    nCompared++;
    if (doeF !== 1'b1) begin nMismatched++; $display("[TB] FAIL rd_doe: got %b want %b", doeF, 1'b1); end
    nCompared++;
    if (doeD !== 1'b1) begin nMismatched++; $display("[TB] FAIL rd_doe_direct: got %b want %b", doeD, 1'b1); end
    nCompared++;
    if (doutF !== statusExp()) begin nMismatched++; $display("[TB] FAIL rd_status: got %h want %h", doutF, statusExp()); end
    step();
    nCompared++;
    if (doutF[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL rd_during: got %b want %b", doutF[0], 1'b1); end
    busIdle();
    #1;
    nCompared++;
    if (doeF !== 1'b0) begin nMismatched++; $display("[TB] FAIL rd_doe_off: got %b want %b", doeF, 1'b0); end
    step();
    urM = 4'h0;
    nCompared++;
    if (doutF[3:0] !== 4'h0) begin nMismatched++; $display("[TB] FAIL rd_clear: got %h want %h", doutF[3:0], 4'h0); end
    iorq = 1'b0; rd = 1'b0; a = 8'hDE;
    #1;
    nCompared++;
    if (doeF !== 1'b0) begin nMismatched++; $display("[TB] FAIL rd_wrong_addr: got %b want %b", doeF, 1'b0); end
    step();
    busIdle();
    step();
    // Read ends on the same clock as an empty tick: the new underrun must survive.
    iorq = 1'b0; rd = 1'b0; a = PS;
    step();
    busIdle();
    tick = 1'b1;
    step();
    urM = 4'h0;
    modelTick();
    busIdle();
    nCompared++;
    if (doutF[3:0] !== 4'hF) begin nMismatched++; $display("[TB] FAIL rd_set_wins: got %h want %h", doutF[3:0], 4'hF); end
    nCompared++;
    if (doutF !== statusExp()) begin nMismatched++; $display("[TB] FAIL rd_set_wins_status: got %h want %h", doutF, statusExp()); end
  endtask

  task automatic test_direct();
    busIdle();
    step();
    iorq = 1'b0; wr = 1'b0; a = P2; d = 8'h12; ce = 1'b1;
    #1;
    nCompared++;
    if (qD[23:16] !== dqM[2]) begin nMismatched++; $display("[TB] FAIL dir_no_comb: got %h want %h", qD[23:16], dqM[2]); end
    step();
    modelPush(P2, 8'h12);
    nCompared++;
    if (qD[23:16] !== 8'h12) begin nMismatched++; $display("[TB] FAIL dir_latency: got %h want %h", qD[23:16], 8'h12); end
    nCompared++;
    if (qD !== dqExp()) begin nMismatched++; $display("[TB] FAIL dir_q_all: got %h want %h", qD, dqExp()); end
    d = 8'h55;
    step();
    nCompared++;
    if (qD[23:16] !== 8'h12) begin nMismatched++; $display("[TB] FAIL dir_one_push: got %h want %h", qD[23:16], 8'h12); end
    busIdle();
    step();
    doTick();
    nCompared++;
    if (qD !== dqExp()) begin nMismatched++; $display("[TB] FAIL dir_tick_ignored: got %h want %h", qD, dqExp()); end
    nCompared++;
    if (doutD !== 8'h00) begin nMismatched++; $display("[TB] FAIL dir_status: got %h want %h", doutD, 8'h00); end
    ioWrite(P0, 8'hC3, 2);
    ioWrite(P1, 8'h3C, 1);
    doTick();
    ioWrite(P0, 8'h99, 1);
    ioWrite(P0, 8'h77, 1);
    nCompared++;
    if (qD !== dqExp()) begin nMismatched++; $display("[TB] FAIL dir_stream: got %h want %h", qD, dqExp()); end
    doReset();
    nCompared++;
    if (qF !== 32'h0) begin nMismatched++; $display("[TB] FAIL midrst_qF: got %h want %h", qF, 32'h0); end
    nCompared++;
    if (qD !== 32'h0) begin nMismatched++; $display("[TB] FAIL midrst_qD: got %h want %h", qD, 32'h0); end
    nCompared++;
    if (doutF !== 8'h00) begin nMismatched++; $display("[TB] FAIL midrst_status: got %h want %h", doutF, 8'h00); end
    doTick();
    nCompared++;
    if (qF !== 32'h0) begin nMismatched++; $display("[TB] FAIL midrst_discard: got %h want %h", qF, 32'h0); end
    nCompared++;
    if (doutF !== 8'h0F) begin nMismatched++; $display("[TB] FAIL midrst_underrun: got %h want %h", doutF, 8'h0F); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      int         op;
      int         burst;
      logic [7:0] port;
      logic [7:0] data;
      op = int'($urandom_range(0, 9));
      case ($urandom_range(0, 4))
        0:       port = P0;
        1:       port = P1;
        2:       port = P2;
        3:       port = P3;
        default: port = 8'($urandom);
      endcase
      data = 8'($urandom);
      if (op < 4) begin
        ioWrite(port, data, 1 + int'($urandom_range(0, 3)));
      end else if (op == 4) begin
        burst = 6 + int'($urandom_range(0, 14));
        for (int b = 0; b < burst; b++) ioWrite(port, 8'($urandom), 1);
      end else if (op < 7) begin
        doTick();
      end else if (op < 9) begin
        pushTick(port, data);
      end else begin
        doRead();
      end
      nCompared++;
      if (qF !== qExp()) begin nMismatched++; $display("[TB] FAIL rnd_qF_%0d: got %h want %h", n, qF, qExp()); end
      nCompared++;
      if (qD !== dqExp()) begin nMismatched++; $display("[TB] FAIL rnd_qD_%0d: got %h want %h", n, qD, dqExp()); end
      nCompared++;
      if (doutF !== statusExp()) begin nMismatched++; $display("[TB] FAIL rnd_status_%0d: got %h want %h", n, doutF, statusExp()); end
    end
  endtask

  initial begin
    busIdle();
    reset = 1'b1;
    modelReset();
    test_reset();
    test_single_push();
    test_full_drop();
    test_full_push_tick();
    test_underrun_push_tick();
    test_status_read();
    test_direct();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
